// File: rtl/midi_voice_parser.sv
// rtl/midi_voice_parser.sv - MIDI byte-stream parser emitting note on/off, CC and panic strobes
// Tracks running status, ignores interleaved real-time bytes and resyncs on any status byte.
module midi_voice_parser #(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter bit         OMNI         = 1'b0,
  parameter bit         VEL0_IS_OFF  = 1'b1,
  parameter bit         CC_EN        = 1'b1
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       midiByteValid_i,
  input  logic [7:0] midiByte_i,
  output logic [6:0] note_o,
  output logic [6:0] velocity_o,
  output logic [3:0] channel_o,
  output logic       noteOnStrb_o,
  output logic       noteOffStrb_o,
  output logic       ccStrb_o,
  output logic       panicStrb_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, D1 = 2'd1, D2 = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic       accept_q, accept_d;
  logic [6:0] data1_q, data1_d;
  logic [6:0] note_q, note_d, vel_q, vel_d;
  logic [3:0] chan_q, chan_d;
  logic       on_q, on_d, off_q, off_d, cc_q, cc_d, panic_q, panic_d;

  logic [3:0] new_type;
  logic       type_ok, chan_ok;

  assign new_type = midiByte_i[7:4];
  assign type_ok  = (new_type == 4'h8) || (new_type == 4'h9) || (CC_EN && (new_type == 4'hB));
  assign chan_ok  = OMNI || (midiByte_i[3:0] == MIDI_CHANNEL);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      status_q <= 8'd0;
      accept_q <= 1'b0;
      data1_q  <= 7'd0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      chan_q   <= 4'd0;
      on_q     <= 1'b0;
      off_q    <= 1'b0;
      cc_q     <= 1'b0;
      panic_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      accept_q <= accept_d;
      data1_q  <= data1_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      chan_q   <= chan_d;
      on_q     <= on_d;
      off_q    <= off_d;
      cc_q     <= cc_d;
      panic_q  <= panic_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    accept_d = accept_q;
    data1_d  = data1_q;
    note_d   = note_q;
    vel_d    = vel_q;
    chan_d   = chan_q;
    on_d     = 1'b0;
    off_d    = 1'b0;
    cc_d     = 1'b0;
    panic_d  = 1'b0;
    if (!(state_q inside {IDLE, D1, D2})) state_d = IDLE;
    if (midiByteValid_i) begin
      if (midiByte_i >= 8'hF8) begin
        // Real-time bytes are transparent to message parsing.
        panic_d = (midiByte_i == 8'hFF);
      end else if (midiByte_i >= 8'hF0) begin
        state_d  = IDLE;
        status_d = 8'd0;
        accept_d = 1'b0;
      end else if (midiByte_i[7]) begin
        state_d  = D1;
        status_d = midiByte_i;
        accept_d = type_ok && chan_ok;
      end else begin
        case (state_q)
          IDLE: ;
          D1: begin
            data1_d = midiByte_i[6:0];
            state_d = ((status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD)) ? D1 : D2;
          end
          D2: begin
            state_d = D1;
            if (accept_q) begin
              note_d = data1_q;
              vel_d  = midiByte_i[6:0];
              chan_d = status_q[3:0];
              case (status_q[7:4])
                4'h9: begin
                  if ((midiByte_i[6:0] != 7'd0) || !VEL0_IS_OFF) on_d = 1'b1;
                  else off_d = 1'b1;
                end
                4'h8: off_d = 1'b1;
                4'hB: begin
                  cc_d    = 1'b1;
                  panic_d = (data1_q == 7'd120) || (data1_q == 7'd123);
                end
                default: ;
              endcase
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign note_o        = note_q;
  assign velocity_o    = vel_q;
  assign channel_o     = chan_q;
  assign noteOnStrb_o  = on_q;
  assign noteOffStrb_o = off_q;
  assign ccStrb_o      = cc_q;
  assign panicStrb_o   = panic_q;

endmodule

// File: tb/tb_midi_voice_parser.sv
// tb/tb_midi_voice_parser.sv - bench for midi_voice_parser with two parameter sets
// Instance 0: defaults; instance 1: OMNI, channel 5, VEL0_IS_OFF=0, CC_EN=0.
module tb_midi_voice_parser;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] mb = 8'd0;

  logic [6:0] note0, vel0, note1, vel1;
  logic [3:0] ch0, ch1;
  logic       on0, off0, cc0, pan0, on1, off1, cc1, pan1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  midi_voice_parser #(.MIDI_CHANNEL(4'd0), .OMNI(1'b0), .VEL0_IS_OFF(1'b1), .CC_EN(1'b1)) u0 (
    .clk_i(clk), .nrst_i(nrst), .midiByteValid_i(vld), .midiByte_i(mb),
    .note_o(note0), .velocity_o(vel0), .channel_o(ch0),
    .noteOnStrb_o(on0), .noteOffStrb_o(off0), .ccStrb_o(cc0), .panicStrb_o(pan0));

  midi_voice_parser #(.MIDI_CHANNEL(4'd5), .OMNI(1'b1), .VEL0_IS_OFF(1'b0), .CC_EN(1'b0)) u1 (
    .clk_i(clk), .nrst_i(nrst), .midiByteValid_i(vld), .midiByte_i(mb),
    .note_o(note1), .velocity_o(vel1), .channel_o(ch1),
    .noteOnStrb_o(on1), .noteOffStrb_o(off1), .ccStrb_o(cc1), .panicStrb_o(pan1));

  // Reference model: message-level view (running status byte + count of collected data bytes).
  bit         p_omni[2], p_v0off[2], p_cc[2];
  logic [3:0] p_ch[2];
  logic [7:0] m_rs[2];
  int         m_cnt[2];
  logic [6:0] m_d1[2], m_note[2], m_vel[2];
  logic [3:0] m_ch[2];
  logic [3:0] m_strb[2];

  typedef struct {
    logic [7:0] b;
    logic [3:0] strb;
    logic [6:0] note;
    logic [6:0] vel;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [7:0] b, input logic [3:0] s,
                              input logic [6:0] n, input logic [6:0] v);
    vec_t e;
    e.b = b; e.strb = s; e.note = n; e.vel = v;
    tbl.push_back(e);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] act_out(input int k);
    if (k == 0) return {note0, vel0, ch0, on0, off0, cc0, pan0};
    return {note1, vel1, ch1, on1, off1, cc1, pan1};
  endfunction

  function automatic logic [21:0] exp_out(input int k);
    return {m_note[k], m_vel[k], m_ch[k], m_strb[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rs[k] = 8'd0; m_cnt[k] = 0; m_d1[k] = 7'd0;
      m_note[k] = 7'd0; m_vel[k] = 7'd0; m_ch[k] = 4'd0; m_strb[k] = 4'd0;
    end
  endtask

  task automatic model_step(input int k, input bit v, input logic [7:0] b);
    logic [3:0] t;
    int need;
    bit wants;
    m_strb[k] = 4'd0;
    if (!v) return;
    if (b >= 8'hF8) begin
      if (b == 8'hFF) m_strb[k] = 4'b0001;
    end else if (b >= 8'hF0) begin
      m_rs[k] = 8'd0; m_cnt[k] = 0;
    end else if (b[7]) begin
      m_rs[k] = b; m_cnt[k] = 0;
    end else if (m_rs[k] != 8'd0) begin
      t = m_rs[k][7:4];
      need = (t == 4'hC || t == 4'hD) ? 1 : 2;
      if (m_cnt[k] == 0) m_d1[k] = b[6:0];
      m_cnt[k]++;
      if (m_cnt[k] == need) begin
        m_cnt[k] = 0;
        wants = (t == 4'h8 || t == 4'h9 || (t == 4'hB && p_cc[k])) &&
                (p_omni[k] || m_rs[k][3:0] == p_ch[k]);
        if (need == 2 && wants) begin
          m_note[k] = m_d1[k]; m_vel[k] = b[6:0]; m_ch[k] = m_rs[k][3:0];
          if (t == 4'h9) m_strb[k] = (b[6:0] == 7'd0 && p_v0off[k]) ? 4'b0100 : 4'b1000;
          else if (t == 4'h8) m_strb[k] = 4'b0100;
          else m_strb[k] = (m_d1[k] == 7'd120 || m_d1[k] == 7'd123) ? 4'b0011 : 4'b0010;
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    vld = v; mb = b;
    @(posedge clk); #1;
    vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model_step(k, v, b);
      cmp($sformatf("inst%0d byte=%h", k, b), 32'(act_out(k)), 32'(exp_out(k)));
    end
  endtask

  task automatic pulse_reset();
    nrst = 1'b0; vld = 1'b0;
    #1;
    model_reset();
    cmp("reset inst0", 32'(act_out(0)), 32'd0);
    cmp("reset inst1", 32'(act_out(1)), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r, c;
    logic [3:0] ty, ch;
    r = $urandom_range(99, 0);
    if (r < 15) begin
      ty = 4'($urandom_range(14, 8));
      c = $urandom_range(3, 0);
      ch = (c == 0) ? 4'd0 : (c == 1) ? 4'd5 : (c == 2) ? 4'd1 : 4'($urandom_range(15, 0));
      return {ty, ch};
    end
    if (r < 22) return 8'($urandom_range(255, 248));
    if (r < 26) return 8'($urandom_range(247, 240));
    c = $urandom_range(9, 0);
    if (c == 0) return 8'd0;
    if (c == 1) return 8'd120;
    if (c == 2) return 8'd123;
    return 8'($urandom_range(127, 0));
  endfunction

  initial begin
    p_omni  = '{1'b0, 1'b1};
    p_v0off = '{1'b1, 1'b0};
    p_cc    = '{1'b1, 1'b0};
    p_ch    = '{4'd0, 4'd5};
    model_reset();

    add(8'h90, 4'h0, 0, 0); add(8'h3C, 4'h0, 0, 0); add(8'h64, 4'b1000, 7'h3C, 7'h64);
    add(8'h40, 4'h0, 0, 0); add(8'h00, 4'b0100, 7'h40, 7'h00);
    add(8'h80, 4'h0, 0, 0); add(8'hF8, 4'h0, 0, 0); add(8'h3C, 4'h0, 0, 0);
    add(8'hFE, 4'h0, 0, 0); add(8'h10, 4'b0100, 7'h3C, 7'h10);
    add(8'h90, 4'h0, 0, 0); add(8'h3C, 4'h0, 0, 0); add(8'hFF, 4'b0001, 0, 0);
    add(8'h64, 4'b1000, 7'h3C, 7'h64);
    add(8'hC0, 4'h0, 0, 0); add(8'h05, 4'h0, 0, 0); add(8'h06, 4'h0, 0, 0);
    add(8'h90, 4'h0, 0, 0); add(8'h3C, 4'h0, 0, 0); add(8'h64, 4'b1000, 7'h3C, 7'h64);
    add(8'hB0, 4'h0, 0, 0); add(8'h7B, 4'h0, 0, 0); add(8'h00, 4'b0011, 7'h7B, 7'h00);
    add(8'h91, 4'h0, 0, 0); add(8'h3C, 4'h0, 0, 0); add(8'h64, 4'h0, 0, 0);
    add(8'h3D, 4'h0, 0, 0); add(8'h50, 4'h0, 0, 0);
    add(8'hF0, 4'h0, 0, 0); add(8'h7E, 4'h0, 0, 0); add(8'h3C, 4'h0, 0, 0);
    add(8'h64, 4'h0, 0, 0); add(8'hF7, 4'h0, 0, 0);
    add(8'h90, 4'h0, 0, 0); add(8'h3C, 4'h0, 0, 0); add(8'h80, 4'h0, 0, 0);
    add(8'h3D, 4'h0, 0, 0); add(8'h20, 4'b0100, 7'h3D, 7'h20);

    repeat (2) @(posedge clk);
    #1;
    cmp("reset inst0", 32'(act_out(0)), 32'd0);
    cmp("reset inst1", 32'(act_out(1)), 32'd0);
    nrst = 1'b1;

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].b);
      cmp($sformatf("tbl[%0d] strobes", i), 32'({on0, off0, cc0, pan0}), 32'(tbl[i].strb));
      if (tbl[i].strb[3:1] != 3'd0) begin
        cmp($sformatf("tbl[%0d] note", i), 32'(note0), 32'(tbl[i].note));
        cmp($sformatf("tbl[%0d] vel", i), 32'(vel0), 32'(tbl[i].vel));
      end
    end

    // Reset mid-message drops the partial note and the running status.
    step(1'b1, 8'h90);
    step(1'b1, 8'h3C);
    pulse_reset();
    step(1'b1, 8'h64);
    cmp("post-reset data strobes", 32'({on0, off0, on1, off1}), 32'd0);
    step(1'b1, 8'h3C);
    step(1'b1, 8'h40);
    cmp("post-reset running status", 32'({on0, off0, on1, off1}), 32'd0);
    step(1'b0, 8'h00);
    step(1'b1, 8'h95);
    step(1'b1, 8'h3C);
    step(1'b1, 8'h00);
    cmp("omni vel0 noteOn", 32'({on1, off1, ch1, vel1}), 32'({2'b10, 4'd5, 7'd0}));

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(399, 0) == 0) pulse_reset();
      else step($urandom_range(9, 0) < 7, rand_byte());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
